// File: rtl/sevenseg_scanner_pkg.sv
// Shared constants and types for the eight-digit seven-segment scanner.
//
// Segment vectors are 7 bits in abc_defg order: seg[6] is segment a and
// seg[0] is segment g. All segment and anode values are active-low.
package sevenseg_scanner_pkg;

    localparam int unsigned NDIGITS = 8;
    localparam int unsigned IDX_W   = $clog2(NDIGITS);

    localparam logic [6:0]         SEG_BLANK = 7'h7F;
    localparam logic [NDIGITS-1:0] AN_OFF    = 8'hFF;

    // Field order of this struct fixes the abc_defg bit order of a segment vector.
    typedef struct packed {
        logic a;
        logic b;
        logic c;
        logic d;
        logic e;
        logic f;
        logic g;
    } seg_t;

endpackage

// File: rtl/sevensegdec.sv
// Hex nibble to active-low seven-segment pattern (abc_defg).
//
// Ports:
//   nibble  in  4  hex value to display
//   seg     out 7  active-low segments, seg[6] = a ... seg[0] = g
module sevensegdec
    import sevenseg_scanner_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    seg_t pattern;

    always_comb begin
        pattern = SEG_BLANK;
        case (nibble)
            4'h0: pattern = 7'h01;
            4'h1: pattern = 7'h4F;
            4'h2: pattern = 7'h12;
            4'h3: pattern = 7'h06;
            4'h4: pattern = 7'h4C;
            4'h5: pattern = 7'h24;
            4'h6: pattern = 7'h20;
            4'h7: pattern = 7'h0F;
            4'h8: pattern = 7'h00;
            4'h9: pattern = 7'h0C;
            4'hA: pattern = 7'h08;
            4'hB: pattern = 7'h60;
            4'hC: pattern = 7'h72;
            4'hD: pattern = 7'h42;
            4'hE: pattern = 7'h30;
            4'hF: pattern = 7'h38;
            default: pattern = SEG_BLANK;
        endcase
    end

    assign seg = pattern;

endmodule

// File: rtl/sevenseg_scanner.sv
// Time-multiplexed driver for an eight-digit common-anode seven-segment display.
//
// A prescaler divides clk into digit slots of PRESCALE cycles; digit_idx walks
// 0..7 once per slot. Display contents are captured into shadow registers on
// a single-cycle load strobe. Outputs are registered (one cycle behind
// digit_idx / shadow state) and the anodes are forced off for the last output
// cycle of each slot so the next digit never ghosts the previous pattern.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   reset      in   1   synchronous, active-high
//   load       in   1   capture data/dp/blank/lzb into shadow registers
//   data       in   32  eight hex nibbles, nibble k drives digit k (0 = rightmost)
//   dp         in   8   decimal-point request per digit, 1 = lit
//   blank      in   8   per-digit blank mask, 1 = dark
//   lzb        in   1   leading-zero blanking enable
//   an         out  8   active-low anodes, at most one low
//   seg        out  7   active-low segments abc_defg
//   dp_n       out  1   active-low decimal point
//   digit_idx  out  3   digit currently being scanned
module sevenseg_scanner
    import sevenseg_scanner_pkg::*;
#(
    parameter int unsigned PRESCALE = 50000  // cycles per digit slot, must be >= 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [4*NDIGITS-1:0] data,
    input  logic [NDIGITS-1:0]   dp,
    input  logic [NDIGITS-1:0]   blank,
    input  logic                 lzb,
    output logic [NDIGITS-1:0]   an,
    output logic [6:0]           seg,
    output logic                 dp_n,
    output logic [IDX_W-1:0]     digit_idx
);

    localparam int unsigned    PW         = $clog2(PRESCALE);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]          presc_q, presc_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [4*NDIGITS-1:0]   data_q;
    logic [NDIGITS-1:0]     dp_q;
    logic [NDIGITS-1:0]     blank_q;
    logic                   lzb_q;
    logic [NDIGITS-1:0]     an_q, an_d;
    logic [6:0]             seg_q, seg_d;
    logic                   dp_n_q, dp_n_d;

    logic                   wrap;
    logic                   blanked;
    logic [NDIGITS-1:0]     lead_zero;
    logic                   upper_zero;
    logic [3:0]             cur_nibble;
    logic [6:0]             dec_seg;

    assign cur_nibble = data_q[{idx_q, 2'b00} +: 4];

    sevensegdec u_dec (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

    // Digit k (k >= 1) is a leading zero when it and every higher nibble are zero.
    always_comb begin
        lead_zero  = '0;
        upper_zero = 1'b1;
        for (int k = NDIGITS - 1; k >= 1; k--) begin
            upper_zero   = upper_zero & (data_q[4*k +: 4] == 4'h0);
            lead_zero[k] = upper_zero;
        end
    end

    always_comb begin
        wrap    = (presc_q == PRESC_LAST);
        presc_d = wrap ? '0 : presc_q + 1'b1;
        idx_d   = wrap ? idx_q + 1'b1 : idx_q;
        blanked = blank_q[idx_q] | (lzb_q & lead_zero[idx_q]);

        an_d   = AN_OFF;
        seg_d  = SEG_BLANK;
        dp_n_d = 1'b1;
        if (!blanked) begin
            seg_d  = dec_seg;
            dp_n_d = ~dp_q[idx_q];
            // Anodes stay off on the slot's last output cycle (ghosting guard).
            if (!wrap) begin
                an_d = AN_OFF ^ (NDIGITS'(1) << idx_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            dp_q    <= '0;
            blank_q <= AN_OFF;
            lzb_q   <= 1'b0;
            an_q    <= AN_OFF;
            seg_q   <= SEG_BLANK;
            dp_n_q  <= 1'b1;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            if (load) begin
                data_q  <= data;
                dp_q    <= dp;
                blank_q <= blank;
                lzb_q   <= lzb;
            end
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_n_q <= dp_n_d;
        end
    end

    assign an        = an_q;
    assign seg       = seg_q;
    assign dp_n      = dp_n_q;
    assign digit_idx = idx_q;

endmodule

// File: doc/sevenseg_scanner.md
SEVENSEG_SCANNER -- requirements
Module: sevenseg_scanner

Interface
REQ-001 Parameter: PRESCALE, 50000, clock cycles per digit slot; SHALL be >= 2.
REQ-002 Port: clk  in  1  system clock; all state SHALL update on the rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: load  in  1  single-cycle strobe; capture data, dp, blank and lzb into shadow registers.
REQ-005 Port: data  in  32  eight hex nibbles; nibble k (bits 4k+3:4k) drives digit k, with digit 0 rightmost.
REQ-006 Port: dp  in  8  decimal-point request per digit, 1 = lit.
REQ-007 Port: blank  in  8  per-digit blank mask, 1 = digit dark.
REQ-008 Port: lzb  in  1  leading-zero blanking enable.
REQ-009 Port: an  out  8  digit anodes, active-low, at most one low.
REQ-010 Port: seg  out  7  segments abc_defg, active-low.
REQ-011 Port: dp_n  out  1  decimal point, active-low.
REQ-012 Port: digit_idx  out  3  index of the digit currently being driven.

Function
REQ-013 A load high at edge t SHALL make the shadow registers hold the new values from t+1; the shadow registers SHALL be unchanged while load is low.
REQ-014 The prescaler SHALL count 0..PRESCALE-1 and wrap to 0.
REQ-015 digit_idx SHALL increment by 1 on the edge where the prescaler wraps, going from 7 back to 0.
REQ-016 Each digit slot SHALL last exactly PRESCALE cycles, and a full frame SHALL last 8*PRESCALE cycles.
REQ-017 an, seg and dp_n SHALL be registered, reflecting the digit_idx and shadow state of the previous cycle (latency 1).
REQ-018 For the driven digit k that is not blanked: an[k]=0, all other an bits = 1, seg = hex decode of nibble k, dp_n = ~dp[k].
REQ-019 Hex decode (seg, in hex) SHALL be:
  - 0->01, 1->4F, 2->12, 3->06
  - 4->4C, 5->24, 6->20, 7->0F
  - 8->00, 9->0C, A->08, B->60
  - C->72, D->42, E->30, F->38
REQ-020 A digit is blanked if its shadow blank bit is 1, or if lzb=1 and the digit is a leading zero.
REQ-021 A leading zero is a digit k >= 1 where nibble k and every higher nibble are zero; digit 0 SHALL never be a leading zero.
REQ-022 For a blanked digit, an SHALL be 8'hFF, seg 7'h7F and dp_n 1.
REQ-023 On the edge where digit_idx changes, an SHALL be 8'hFF for that output cycle (one-cycle ghosting guard); seg and dp_n SHALL still follow REQ-018.
REQ-024 load arriving mid-slot SHALL NOT reset the prescaler or digit_idx; the new value SHALL appear on the outputs from t+2.
REQ-025 If load coincides with a prescaler wrap, the advance and the capture SHALL both take effect; the new digit SHALL show the new data.

Reset
REQ-026 When reset is high at an edge:
  - prescaler = 0 and digit_idx = 0;
  - shadow data = 0, dp = 0, blank = 8'hFF, lzb = 0;
  - an = 8'hFF, seg = 7'h7F, dp_n = 1.
REQ-027 Reset SHALL take priority over load and over the prescaler wrap.
REQ-028 Asserting reset mid-frame SHALL return the block to the REQ-026 state within one edge.

Structure
REQ-029 A shared package/header SHALL hold:
  - NDIGITS = 8;
  - SEG_BLANK = 7'h7F;
  - AN_OFF = 8'hFF;
  - the abc_defg bit order.
REQ-030 The block SHALL instantiate the existing sevensegdec as its single sub-module, fed by the nibble selected by digit_idx.
REQ-031 The prescaler width SHALL be $clog2(PRESCALE); the rest is flat RTL.

Verification (PRESCALE=4)
REQ-032 Reset, then hold reset low with no load -> an=FF, seg=7F, dp_n=1 held for 8*4 cycles.
REQ-033 load data=0x01234567, blank=00, dp=01, lzb=0 -> digit 0 slot: an=FE, seg=0F, dp_n=0; 4 cycles later: guard cycle an=FF, then an=FD, seg=20, dp_n=1.
REQ-034 Same data, observe a full frame -> digit 7: an=7F, seg=01; the next slot wraps to digit_idx=0.
REQ-035 load data=0x000000A0, lzb=1, blank=00 -> digits 7..2 give an=FF; digit 1: an=FD, seg=08; digit 0: an=FE, seg=01.
REQ-036 load 0x0000000F at prescaler=1 within digit 0's slot -> digit_idx and slot timing unchanged; seg=38 from t+2.
REQ-037 Assert reset during digit 5 -> next edge: digit_idx=0, an=FF, seg=7F, blank=FF.
